btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  N-channel push-button conditioner. Sits between the board buttons and control logic (counter/SPI/I2C masters).
//  Per channel: synchronise, debounce by stable-sample count on a shared sample tick, then emit a clean level
//  plus one-cycle press/release/long-press/auto-repeat event pulses.
// PARAMETERS
//  N_CH         4    number of independent button channels
//  TICK_DIV     100  clk cycles per sample tick (>=2); 100 -> 1 MHz tick at 100 MHz clk
//  STABLE_CNT   8    consecutive differing samples required to accept a new level (>=1)
//  LONG_TICKS   1000 ticks of held level before o_long fires (>=1)
//  REPEAT_TICKS 250  ticks between o_repeat pulses after o_long; 0 disables repeat
//  ACTIVE_LOW   0    1: raw input is inverted (pressed = 0 on pin)
// PORTS
//  clk        in   1     system clock
//  reset      in   1     asynchronous, active-high reset
//  i_btn      in   N_CH  raw asynchronous button inputs
//  o_level    out  N_CH  debounced level, 1 = pressed
//  o_press    out  N_CH  1-cycle pulse on debounced 0->1
//  o_release  out  N_CH  1-cycle pulse on debounced 1->0
//  o_long     out  N_CH  1-cycle pulse when held LONG_TICKS ticks
//  o_repeat   out  N_CH  1-cycle pulse every REPEAT_TICKS ticks after o_long while held
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; tick counter, sync FFs, stab/hold counters 0; FSMs IDLE.
//   Sync FFs reset to ACTIVE_LOW so corrected sample is 0; no event pulse in first cycle after reset release.
//  Sync: 2-FF synchroniser per channel on clk; corrected sample s = sync2 ^ ACTIVE_LOW.
//  Tick: shared counter 0..TICK_DIV-1 wraps; tick = 1 for the one cycle where counter == TICK_DIV-1.
//  Debounce, only on tick cycles: s != o_level -> stab_cnt++; s == o_level -> stab_cnt = 0.
//   When s != o_level and stab_cnt == STABLE_CNT-1: o_level toggles at that edge, stab_cnt = 0.
//   Glitches shorter than STABLE_CNT consecutive ticks never change o_level.
//  Events are registered and coincide with the first cycle of the new o_level value (latency 0 vs o_level).
//  Per-channel FSM (advances only on tick, except outputs are pulses of exactly 1 clk):
//   IDLE  : o_level 0. Accept press -> SHORT, hold_cnt = 0, o_press.
//   SHORT : hold_cnt++ per tick; hold_cnt reaches LONG_TICKS -> LONG, o_long, rep_cnt = 0.
//           Accept release -> IDLE, o_release.
//   LONG  : rep_cnt++ per tick; rep_cnt == REPEAT_TICKS (REPEAT_TICKS != 0) -> o_repeat, rep_cnt = 0.
//           Accept release -> IDLE, o_release; no o_repeat in the release cycle.
//  Counter widths: stab $clog2(STABLE_CNT+1), hold $clog2(LONG_TICKS+1), rep $clog2(REPEAT_TICKS+1); no overflow
//   (hold stops at LONG_TICKS, rep wraps to 0 at REPEAT_TICKS).
//  Channels fully independent; simultaneous events on several channels all pulse in the same cycle.
//  Reset mid-hold: outputs drop asynchronously; no o_release generated.
// TESTING  (bench params: N_CH=2, TICK_DIV=4, STABLE_CNT=3, LONG_TICKS=10, REPEAT_TICKS=5, ACTIVE_LOW=0)
//  1 i_btn[0]=1 for 2 ticks then 0 -> o_level stays 0, no pulses on any output.
//  2 i_btn[0]=1 held -> o_level[0] rises at 3rd tick after sync (within 14 clk of input edge);
//    o_press[0] exactly 1 cycle, same cycle as o_level rise.
//  3 keep held 20 ticks after press -> o_long[0] once at tick 10; o_repeat[0] at ticks 15 and 20.
//  4 release after test 3 -> o_release[0] 1 cycle after 3 stable low ticks; no further long/repeat.
//    Press both channels same clk -> o_press[1:0]=2'b11 in one cycle.
//  5 assert reset during LONG -> all outputs 0 same cycle; after release, no o_release/o_press.
//  6 ACTIVE_LOW=1, i_btn held 1 through reset -> o_level 0, no events; drive 0 -> press after 3 ticks.

Source files
------------

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF sync, tick-sampled debounce, and
// registered press/release/long/repeat pulses per channel.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100,
  parameter int STABLE_CNT   = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int STAB_W = $clog2(STABLE_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [N_CH-1:0]   POLARITY  = {N_CH{ACTIVE_LOW}};
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [N_CH-1:0]   sync1, sync2, sample, accept;

  state_t            state    [N_CH];
  logic [STAB_W-1:0] stab_cnt [N_CH];
  logic [HOLD_W-1:0] hold_cnt [N_CH];
  logic [REP_W-1:0]  rep_cnt  [N_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Sync FFs reset to the idle pin level so the corrected sample starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= POLARITY;
      sync2 <= POLARITY;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
    end
  end

  assign sample = sync2 ^ POLARITY;

  always_comb begin
    accept = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      accept[ch] = tick && (sample[ch] != o_level[ch]) && (stab_cnt[ch] == STAB_LAST);
    end
  end

  // Level and FSM share one register block so events land on the first cycle of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_level   <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_long    <= '0;
      o_repeat  <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        state[ch]    <= IDLE;
        stab_cnt[ch] <= '0;
        hold_cnt[ch] <= '0;
        rep_cnt[ch]  <= '0;
      end
    end else begin
      o_press   <= '0;
      o_release <= '0;
      o_long    <= '0;
      o_repeat  <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (tick) begin
          if (sample[ch] == o_level[ch] || accept[ch]) begin
            stab_cnt[ch] <= '0;
          end else begin
            stab_cnt[ch] <= stab_cnt[ch] + STAB_W'(1);
          end

          case (state[ch])
            IDLE: begin
              if (accept[ch]) begin
                state[ch]    <= SHORT;
                o_level[ch]  <= 1'b1;
                o_press[ch]  <= 1'b1;
                hold_cnt[ch] <= '0;
              end
            end
            SHORT: begin
              if (accept[ch]) begin
                state[ch]     <= IDLE;
                o_level[ch]   <= 1'b0;
                o_release[ch] <= 1'b1;
              end else if (hold_cnt[ch] == HOLD_LAST) begin
                state[ch]    <= LONG;
                hold_cnt[ch] <= HOLD_MAX;
                o_long[ch]   <= 1'b1;
                rep_cnt[ch]  <= '0;
              end else begin
                hold_cnt[ch] <= hold_cnt[ch] + HOLD_W'(1);
              end
            end
            LONG: begin
              // Release wins over a repeat due on the same tick.
              if (accept[ch]) begin
                state[ch]     <= IDLE;
                o_level[ch]   <= 1'b0;
                o_release[ch] <= 1'b1;
              end else if (REPEAT_TICKS != 0) begin
                if (rep_cnt[ch] == REP_LAST) begin
                  o_repeat[ch] <= 1'b1;
                  rep_cnt[ch]  <= '0;
                end else begin
                  rep_cnt[ch] <= rep_cnt[ch] + REP_W'(1);
                end
              end
            end
            default: state[ch] <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: a 2-channel active-high instance plus a 1-channel
// active-low instance, checked against a tick-level reference model and a vector table.
module tb_btn_debounce_multi;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_CNT   = 3;
  localparam int LONG_TICKS   = 10;
  localparam int REPEAT_TICKS = 5;
  localparam logic [2:0] AL_MASK = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] pin;

  logic [1:0] a_level, a_press, a_rel, a_long, a_rep;
  logic       b_level, b_press, b_rel, b_long, b_rep;

  btn_debounce_multi #(
    .N_CH(2), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .i_btn(pin[1:0]),
    .o_level(a_level), .o_press(a_press), .o_release(a_rel),
    .o_long(a_long), .o_repeat(a_rep)
  );

  btn_debounce_multi #(
    .N_CH(1), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .i_btn(pin[2]),
    .o_level(b_level), .o_press(b_press), .o_release(b_rel),
    .o_long(b_long), .o_repeat(b_rep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pin;
    int         cycles;
    logic [2:0] lvl;
    int         np, nr, nl, nrep;
  } vec_t;

  vec_t tbl [10];
  int   passCount = 0;
  int   checkCount = 0;
  int   cyc = 0;
  int   seg_press, seg_rel, seg_long, seg_rep;
  logic seen_both;

  // Reference model: channel 2 is the active-low instance; samples are stored already corrected.
  int         m_tcnt;
  logic [2:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_long, m_rep;
  int         m_run  [3];
  int         m_held [3];

  function automatic logic [14:0] dutVec();
    return {b_level, a_level, b_press, a_press, b_rel, a_rel, b_long, a_long, b_rep, a_rep};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, required);
  endtask

  task automatic modelReset();
    m_tcnt = 0;
    {m_s1, m_s2, m_lvl, m_press, m_rel, m_long, m_rep} = '0;
    for (int c = 0; c < 3; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  // Held time is tracked as plain ticks since the press; long/repeat follow from arithmetic on it.
  task automatic modelStep();
    logic       tick, toggled;
    logic [2:0] s;
    if (reset) modelReset();
    else begin
      tick   = (m_tcnt == TICK_DIV - 1);
      m_tcnt = (m_tcnt + 1) % TICK_DIV;
      s      = m_s2;
      m_s2   = m_s1;
      m_s1   = pin ^ AL_MASK;
      {m_press, m_rel, m_long, m_rep} = '0;
      if (tick) begin
        for (int c = 0; c < 3; c++) begin
          toggled = 1'b0;
          if (s[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == STABLE_CNT) begin
              m_run[c] = 0;
              m_lvl[c] = s[c];
              toggled  = 1'b1;
              if (s[c]) begin
                m_press[c] = 1'b1;
                m_held[c]  = 0;
              end else m_rel[c] = 1'b1;
            end
          end else m_run[c] = 0;
          if (!toggled && m_lvl[c]) begin
            m_held[c]++;
            if (m_held[c] == LONG_TICKS) m_long[c] = 1'b1;
            else if (REPEAT_TICKS != 0 && m_held[c] > LONG_TICKS &&
                     (m_held[c] - LONG_TICKS) % REPEAT_TICKS == 0) m_rep[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    checkOutput("cycle_vs_model", 32'(dutVec()), 32'({m_lvl, m_press, m_rel, m_long, m_rep}));
    seg_press += $countones({b_press, a_press});
    seg_rel   += $countones({b_rel, a_rel});
    seg_long  += $countones({b_long, a_long});
    seg_rep   += $countones({b_rep, a_rep});
    if (a_press == 2'b11) seen_both = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [2:0] value, input int cycles);
    pin = value;
    seg_press = 0; seg_rel = 0; seg_long = 0; seg_rep = 0;
    seen_both = 1'b0;
    repeat (cycles) runCycle();
  endtask

  task automatic doReset(input logic [2:0] value);
    pin   = value;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_async", 32'(dutVec()), 32'd0);
    runCycle();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{3'b101,  8, 3'b000, 0, 0, 0, 0};
    tbl[1] = '{3'b100, 12, 3'b000, 0, 0, 0, 0};
    tbl[2] = '{3'b101, 12, 3'b001, 1, 0, 0, 0};
    tbl[3] = '{3'b101, 80, 3'b001, 0, 0, 1, 2};
    tbl[4] = '{3'b100, 12, 3'b000, 0, 1, 0, 0};
    tbl[5] = '{3'b100, 40, 3'b000, 0, 0, 0, 0};
    tbl[6] = '{3'b111, 12, 3'b011, 2, 0, 0, 0};
    tbl[7] = '{3'b100, 12, 3'b000, 0, 2, 0, 0};
    tbl[8] = '{3'b000, 12, 3'b100, 1, 0, 0, 0};
    tbl[9] = '{3'b100, 12, 3'b000, 0, 1, 0, 0};

    reset = 1'b1;
    pin   = 3'b100;
    @(negedge clk);
    doReset(3'b100);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].pin, tbl[i].cycles);
      checkOutput($sformatf("row%0d_level", i), 32'({b_level, a_level}), 32'(tbl[i].lvl));
      checkOutput($sformatf("row%0d_events", i),
                  {8'(seg_press), 8'(seg_rel), 8'(seg_long), 8'(seg_rep)},
                  {8'(tbl[i].np), 8'(tbl[i].nr), 8'(tbl[i].nl), 8'(tbl[i].nrep)});
      if (i == 6) checkOutput("both_press_same_cycle", 32'(seen_both), 32'd1);
    end

    // Reset while channel 0 sits in the long-hold state.
    applyStimulus(3'b101, 56);
    checkOutput("long_level", 32'(a_level[0]), 32'd1);
    checkOutput("long_once", 32'(seg_long), 32'd1);
    doReset(3'b100);
    applyStimulus(3'b100, 40);
    checkOutput("post_reset_level", 32'({b_level, a_level}), 32'd0);
    checkOutput("post_reset_events", 32'(seg_press + seg_rel + seg_long + seg_rep), 32'd0);

    for (int i = 0; i < 40; i++) begin
      if (i == 20) doReset(3'($urandom));
      applyStimulus(3'($urandom),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(20, 80));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
